obstacle_spawn_scheduler: RTL and testbench

Sequences the obstacle datapath during the PLAYING state. It times spawns off the frame tick and picks a free obstacle slot round-robin. It issues each spawn through a valid/ready handshake. It also escalates difficulty, raising obstacle speed and shortening the spawn interval as the spawn count grows. It sits between the game state machine/RNG and the per-slot obstacle controllers.

---
 rtl/obstacle_spawn_scheduler_pkg.sv | 17 +
 rtl/obstacle_spawn_scheduler_rr_slot_picker.sv | 28 ++
 rtl/obstacle_spawn_scheduler.sv | 174 +++++++++++++++++
 tb/tb_obstacle_spawn_scheduler.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/obstacle_spawn_scheduler_pkg.sv
// rtl/obstacle_spawn_scheduler_pkg.sv - shared scheduler state type and game default constants
package obstacle_spawn_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        SELECT = 2'd2,
        ISSUE  = 2'd3
    } sched_state_t;

    // Also consumed by obstacle_control so both agree on spawn geometry and pacing.
    localparam int          DEF_BASE_INTERVAL = 60;
    localparam int          DEF_MIN_INTERVAL  = 15;
    localparam logic [9:0]  DEF_BASE_SPEED    = 10'd5;
    localparam logic [9:0]  DEF_Y_MIN         = 10'd50;

endpackage

// File: rtl/obstacle_spawn_scheduler_rr_slot_picker.sv
// rtl/obstacle_spawn_scheduler_rr_slot_picker.sv - round-robin free-slot picker (rotate then priority-encode)
module rr_slot_picker #(
    parameter int NUM_SLOTS = 4,
    parameter int SLOT_W    = 2
) (
    input  logic [NUM_SLOTS-1:0] free_i,
    input  logic [SLOT_W-1:0]    rr_ptr_i,
    output logic                 found_o,
    output logic [SLOT_W-1:0]    slot_o
);

    logic [SLOT_W-1:0] idx;

    // Walk from the farthest offset back to rr_ptr so the closest free slot wins.
    always_comb begin
        found_o = 1'b0;
        slot_o  = '0;
        idx     = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            idx = rr_ptr_i + SLOT_W'(i);
            if (free_i[idx]) begin
                found_o = 1'b1;
                slot_o  = idx;
            end
        end
    end

endmodule

// File: rtl/obstacle_spawn_scheduler.sv
// rtl/obstacle_spawn_scheduler.sv - frame-tick spawn timer, round-robin slot issue and difficulty escalation
module obstacle_spawn_scheduler
    import obstacle_spawn_scheduler_pkg::*;
#(
    parameter int          NUM_SLOTS        = 4,
    parameter int          SLOT_W           = 2,
    parameter int          BASE_INTERVAL    = DEF_BASE_INTERVAL,
    parameter int          INTERVAL_STEP    = 5,
    parameter int          MIN_INTERVAL     = DEF_MIN_INTERVAL,
    parameter int          SPAWNS_PER_LEVEL = 8,
    parameter int          MAX_LEVEL        = 7,
    parameter logic [9:0]  BASE_SPEED       = DEF_BASE_SPEED,
    parameter logic [9:0]  Y_MIN            = DEF_Y_MIN
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  game_en,
    input  logic                  playing,
    input  logic [9:0]            rand_in,
    input  logic [NUM_SLOTS-1:0]  slot_busy,
    input  logic                  spawn_ready,
    output logic                  spawn_valid,
    output logic [SLOT_W-1:0]     spawn_slot,
    output logic [9:0]            spawn_y,
    output logic [9:0]            speed,
    output logic [2:0]            level,
    output logic [7:0]            spawn_count
);

    localparam int CNT_W     = $clog2(BASE_INTERVAL + 1);
    localparam int LVL_CNT_W = $clog2(SPAWNS_PER_LEVEL + 1);

    sched_state_t          state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [LVL_CNT_W-1:0]  lvl_cnt_q, lvl_cnt_d;
    logic [SLOT_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [2:0]            level_q, level_d;
    logic [9:0]            speed_q, speed_d;
    logic [7:0]            count_q, count_d;
    logic                  valid_q, valid_d;
    logic [SLOT_W-1:0]     slot_q, slot_d;
    logic [9:0]            y_q, y_d;

    logic                  pick_found;
    logic [SLOT_W-1:0]     pick_slot;
    logic [2:0]            level_nxt;

    // Compare before subtracting so a deep level never wraps below the floor.
    function automatic logic [CNT_W-1:0] interval_for(input logic [2:0] lvl);
        int dec;
        dec = int'(lvl) * INTERVAL_STEP;
        if (BASE_INTERVAL > MIN_INTERVAL + dec)
            return CNT_W'(BASE_INTERVAL - dec);
        else
            return CNT_W'(MIN_INTERVAL);
    endfunction

    rr_slot_picker #(
        .NUM_SLOTS (NUM_SLOTS),
        .SLOT_W    (SLOT_W)
    ) u_picker (
        .free_i   (~slot_busy),
        .rr_ptr_i (rr_ptr_q),
        .found_o  (pick_found),
        .slot_o   (pick_slot)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lvl_cnt_d = lvl_cnt_q;
        rr_ptr_d  = rr_ptr_q;
        level_d   = level_q;
        speed_d   = speed_q;
        count_d   = count_q;
        valid_d   = valid_q;
        slot_d    = slot_q;
        y_d       = y_q;
        level_nxt = level_q;

        if (!playing) begin
            state_d   = IDLE;
            cnt_d     = CNT_W'(BASE_INTERVAL);
            lvl_cnt_d = '0;
            rr_ptr_d  = '0;
            level_d   = '0;
            speed_d   = BASE_SPEED;
            count_d   = '0;
            valid_d   = 1'b0;
            slot_d    = '0;
            y_d       = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = COUNT;
                    cnt_d   = CNT_W'(BASE_INTERVAL);
                end
                COUNT: begin
                    if (game_en) begin
                        cnt_d = cnt_q - 1'b1;
                        if (cnt_q == CNT_W'(1))
                            state_d = SELECT;
                    end
                end
                SELECT: begin
                    if (pick_found) begin
                        slot_d  = pick_slot;
                        y_d     = Y_MIN + {2'b00, rand_in[7:0]};
                        valid_d = 1'b1;
                        state_d = ISSUE;
                    end else begin
                        // Leave the timer one tick from expiry so the search retries next frame.
                        cnt_d   = CNT_W'(1);
                        state_d = COUNT;
                    end
                end
                ISSUE: begin
                    if (valid_q && spawn_ready) begin
                        valid_d  = 1'b0;
                        rr_ptr_d = slot_q + 1'b1;
                        if (count_q != 8'hFF)
                            count_d = count_q + 1'b1;
                        if (lvl_cnt_q == LVL_CNT_W'(SPAWNS_PER_LEVEL - 1)) begin
                            lvl_cnt_d = '0;
                            if (level_q != 3'(MAX_LEVEL))
                                level_nxt = level_q + 1'b1;
                        end else begin
                            lvl_cnt_d = lvl_cnt_q + 1'b1;
                        end
                        level_d = level_nxt;
                        speed_d = BASE_SPEED + {7'd0, level_nxt};
                        cnt_d   = interval_for(level_nxt);
                        state_d = COUNT;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= CNT_W'(BASE_INTERVAL);
            lvl_cnt_q <= '0;
            rr_ptr_q  <= '0;
            level_q   <= '0;
            speed_q   <= BASE_SPEED;
            count_q   <= '0;
            valid_q   <= 1'b0;
            slot_q    <= '0;
            y_q       <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lvl_cnt_q <= lvl_cnt_d;
            rr_ptr_q  <= rr_ptr_d;
            level_q   <= level_d;
            speed_q   <= speed_d;
            count_q   <= count_d;
            valid_q   <= valid_d;
            slot_q    <= slot_d;
            y_q       <= y_d;
        end
    end

    assign spawn_valid = valid_q;
    assign spawn_slot  = slot_q;
    assign spawn_y     = y_q;
    assign speed       = speed_q;
    assign level       = level_q;
    assign spawn_count = count_q;

endmodule

// File: tb/tb_obstacle_spawn_scheduler.sv
// tb/tb_obstacle_spawn_scheduler.sv - directed self-checking bench for obstacle_spawn_scheduler
module tb_obstacle_spawn_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       game_en;
    logic       playing;
    logic [9:0] rand_in;
    logic [3:0] slot_busy;
    logic       spawn_ready;
    logic       spawn_valid;
    logic [1:0] spawn_slot;
    logic [9:0] spawn_y;
    logic [9:0] speed;
    logic [2:0] level;
    logic [7:0] spawn_count;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    obstacle_spawn_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .game_en     (game_en),
        .playing     (playing),
        .rand_in     (rand_in),
        .slot_busy   (slot_busy),
        .spawn_ready (spawn_ready),
        .spawn_valid (spawn_valid),
        .spawn_slot  (spawn_slot),
        .spawn_y     (spawn_y),
        .speed       (speed),
        .level       (level),
        .spawn_count (spawn_count)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            game_en = 1'b1;
            step();
            game_en = 1'b0;
            repeat (3) step();
        end
    endtask

    task automatic wait_spawn(output int ticks);
        ticks = 0;
        while (!spawn_valid && ticks < 200) begin
            do_ticks(1);
            ticks++;
        end
        if (!spawn_valid) check("spawn_timeout", 0, 1);
    endtask

    task automatic accept();
        spawn_ready = 1'b1;
        step();
        spawn_ready = 1'b0;
    endtask

    int t;
    logic [1:0] held_slot;
    logic [9:0] held_y;

    initial begin
        rst = 1'b0; game_en = 1'b0; playing = 1'b0;
        rand_in = 10'h3A7; slot_busy = 4'h0; spawn_ready = 1'b0;
        repeat (2) step();
        check("rst_valid", spawn_valid, 0);
        check("rst_speed", speed, 5);
        check("rst_level", level, 0);
        check("rst_count", spawn_count, 0);
        rst = 1'b1;
        step();
        playing = 1'b1;
        repeat (2) step();

        // first spawn: 60 ticks, valid two clk after terminal tick
        do_ticks(59);
        check("pre_term_valid", spawn_valid, 0);
        game_en = 1'b1;
        step();
        game_en = 1'b0;
        check("select_valid", spawn_valid, 0);
        step();
        check("issue_valid", spawn_valid, 1);
        check("first_slot", spawn_slot, 0);
        check("first_y", spawn_y, 217);
        accept();
        check("first_count", spawn_count, 1);
        check("post_hs_valid", spawn_valid, 0);

        // round robin from rr_ptr=1 with slots 1,2 busy, then wrap
        slot_busy = 4'b0110; rand_in = 10'h0FF;
        do_ticks(60);
        check("rr_slot3", spawn_slot, 3);
        check("rr_y", spawn_y, 305);
        accept();
        slot_busy = 4'h0;
        do_ticks(60);
        check("rr_wrap_slot0", spawn_slot, 0);
        accept();
        check("count3", spawn_count, 3);

        // all busy: no request, retry on next tick
        slot_busy = 4'hF;
        do_ticks(60);
        check("full_valid", spawn_valid, 0);
        check("full_count", spawn_count, 3);
        slot_busy = 4'hB;
        do_ticks(1);
        check("retry_valid", spawn_valid, 1);
        check("retry_slot2", spawn_slot, 2);
        accept();
        slot_busy = 4'h0;

        // escalate to level 1
        for (int k = 4; k < 8; k++) begin
            wait_spawn(t);
            accept();
        end
        check("lvl1_count", spawn_count, 8);
        check("lvl1_level", level, 1);
        check("lvl1_speed", speed, 6);
        wait_spawn(t);
        check("lvl1_interval", t, 55);
        accept();

        for (int k = 9; k < 64; k++) begin
            wait_spawn(t);
            accept();
        end
        check("sat_count64", spawn_count, 64);
        check("sat_level64", level, 7);
        for (int k = 64; k < 72; k++) begin
            wait_spawn(t);
            accept();
        end
        check("sat_level72", level, 7);
        check("sat_speed72", speed, 12);
        wait_spawn(t);
        check("sat_interval", t, 25);

        // stalled request keeps slot and y stable
        held_slot = spawn_slot;
        held_y    = spawn_y;
        rand_in   = 10'h155;
        slot_busy = 4'hF;
        repeat (5) step();
        check("stall_valid", spawn_valid, 1);
        check("stall_slot", spawn_slot, held_slot);
        check("stall_y", spawn_y, held_y);
        check("stall_count", spawn_count, 72);

        // async reset mid-ISSUE acts without a clock edge
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("arst_valid", spawn_valid, 0);
        check("arst_level", level, 0);
        check("arst_speed", speed, 5);
        check("arst_count", spawn_count, 0);
        step();
        rst = 1'b1;
        slot_busy = 4'h0;
        repeat (2) step();
        wait_spawn(t);
        check("arst_interval", t, 60);

        // playing drops with a handshake in the same cycle
        spawn_ready = 1'b1;
        playing = 1'b0;
        step();
        spawn_ready = 1'b0;
        check("drop_valid", spawn_valid, 0);
        check("drop_count", spawn_count, 0);
        check("drop_state", dut.state_q, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
